// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, FSM encoding and FIFO sizing for the pointwise-multiply controller
package pwm_pkg;
    localparam int Q = 8380417;
    localparam int COEF_W = 23;
    localparam int LANE_SLOT = 32;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE} state_t;
    function automatic int fifo_depth(input int mul_lat);
        return mul_lat + 2;
    endfunction
endpackage

// File: rtl/pwm_res_fifo.sv
// pwm_res_fifo: first-word-fall-through result FIFO with occupancy count
module pwm_res_fifo #(
    parameter int W = 47,
    parameter int DEPTH = 5,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    assign valid = count != '0;
    assign dout = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pwm_lane_ctrl.sv
// pwm_lane_ctrl: lane-parallel pointwise multiply controller (load vector, stream matrix polys).
// Optional PWM_STATS_EN adds the stall_cnt output.
module pwm_lane_ctrl #(
    parameter int COEF_W = pwm_pkg::COEF_W,
    parameter int N = 256,
    parameter int LANES = 2,
    parameter int MUL_LAT = 3,
    parameter int ADDR_W = $clog2(N / LANES),
    parameter int DATA_W = 32 * LANES
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    Matrix_mul_start,
    input  logic [3:0]              column_length,
    input  logic                    Rm_tvalid,
    output logic                    Rm_tready,
    input  logic [DATA_W-1:0]       Rm_tdata,
    input  logic                    Rm_tlast,
    output logic                    Ws_tvalid,
    input  logic                    Ws_tready,
    output logic [DATA_W-1:0]       Ws_tdata,
    output logic [DATA_W/8-1:0]     Ws_tkeep,
    output logic                    Ws_tlast,
    output logic                    coef_we,
    output logic [ADDR_W-1:0]       coef_addra,
    output logic [LANES*COEF_W-1:0] coef_dina,
    output logic                    coef_enb,
    output logic [ADDR_W-1:0]       coef_addrb,
    input  logic [LANES*COEF_W-1:0] coef_doutb,
    output logic [LANES*COEF_W-1:0] mat_a,
    output logic [LANES*COEF_W-1:0] mat_b,
    input  logic [LANES*COEF_W-1:0] mul_result,
    output logic                    Matrix_mul_done,
    output logic                    busy,
    output logic                    proto_err
`ifdef PWM_STATS_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);
    import pwm_pkg::*;
    localparam int BEATS = N / LANES;
    localparam int DEPTH = fifo_depth(MUL_LAT);
    localparam int PW = LANES * COEF_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS - 1);

    state_t state, state_nx;
    logic [3:0] col_len, in_poly, out_poly;
    logic [ADDR_W-1:0] beat_idx;
    logic [PW-1:0] rm_lanes, rm_q, fifo_data;
    logic [MUL_LAT-1:0] pipe_v, pipe_last;
    logic [CW-1:0] fifo_count;
    logic op_v, op_last, fifo_last, accept, beat_last, ws_fire, final_out, done_q, rm_unused;

    assign accept = Rm_tvalid && Rm_tready;
    assign beat_last = beat_idx == LAST_BEAT;
    assign ws_fire = Ws_tvalid && Ws_tready;
    assign final_out = ws_fire && Ws_tlast && out_poly == col_len - 4'd1;
    assign rm_unused = ^Rm_tdata;

    always_comb begin
        rm_lanes = '0;
        Ws_tdata = '0;
        for (int i = 0; i < LANES; i++) begin
            rm_lanes[COEF_W*i +: COEF_W] = Rm_tdata[LANE_SLOT*i +: COEF_W];
            Ws_tdata[LANE_SLOT*i +: COEF_W] = fifo_data[COEF_W*i +: COEF_W];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else state <= state_nx;
    end

    // Credit covers every product already committed to the multiplier so the FIFO can never overflow.
    always_comb begin
        state_nx = state;
        if (state == S_IDLE && Matrix_mul_start) state_nx = S_LOAD;
        else if (state == S_LOAD && accept && beat_last) state_nx = (col_len == 4'd0) ? S_IDLE : S_COMPUTE;
        else if (state == S_COMPUTE && final_out) state_nx = S_IDLE;
        Rm_tready = (state == S_LOAD) || (state == S_COMPUTE && in_poly < col_len &&
                    int'(fifo_count) + $countones({op_v, pipe_v}) < DEPTH);
        busy = state != S_IDLE;
        coef_we = state == S_LOAD && accept;
        coef_enb = state == S_COMPUTE && accept;
    end

    assign coef_addra = beat_idx;
    assign coef_addrb = beat_idx;
    assign coef_dina = coef_we ? rm_lanes : '0;
    assign mat_a = op_v ? rm_q : '0;
    assign mat_b = op_v ? coef_doutb : '0;
    assign Ws_tkeep = '1;
    assign Matrix_mul_done = done_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            col_len <= '0;
            in_poly <= '0;
            out_poly <= '0;
            beat_idx <= '0;
            proto_err <= 1'b0;
            rm_q <= '0;
            op_v <= 1'b0;
            op_last <= 1'b0;
            pipe_v <= '0;
            pipe_last <= '0;
            done_q <= 1'b0;
        end else begin
            if (state == S_IDLE && Matrix_mul_start) begin
                col_len <= column_length;
                proto_err <= 1'b0;
                beat_idx <= '0;
                in_poly <= '0;
                out_poly <= '0;
            end
            if (accept) begin
                beat_idx <= beat_last ? '0 : beat_idx + 1'b1;
                if (state == S_COMPUTE && beat_last) in_poly <= in_poly + 4'd1;
                if (Rm_tlast != beat_last) proto_err <= 1'b1;
            end
            if (ws_fire && Ws_tlast) out_poly <= out_poly + 4'd1;
            if (coef_enb) rm_q <= rm_lanes;
            op_v <= coef_enb;
            op_last <= beat_last;
            pipe_v[0] <= op_v;
            pipe_last[0] <= op_last;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            done_q <= (state == S_LOAD && accept && beat_last && col_len == 4'd0) ||
                      (state == S_COMPUTE && final_out);
        end
    end

    pwm_res_fifo #(.W(PW + 1), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk    (clk),
        .aresetn(aresetn),
        .push   (pipe_v[MUL_LAT-1]),
        .din    ({pipe_last[MUL_LAT-1], mul_result}),
        .pop    (ws_fire),
        .dout   ({fifo_last, fifo_data}),
        .valid  (Ws_tvalid),
        .count  (fifo_count)
    );
    assign Ws_tlast = fifo_last;

`ifdef PWM_STATS_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) stall_cnt <= '0;
        else if (state == S_IDLE && Matrix_mul_start) stall_cnt <= '0;
        else if (state == S_COMPUTE && Ws_tvalid && !Ws_tready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pwm_lane_ctrl.sv
// tb_pwm_lane_ctrl: directed/randomized bench with BRAM and mod-q multiplier models and a product scoreboard
module tb_pwm_lane_ctrl;
    localparam int ML = 5;
    localparam int NB = 128;
    localparam int PW = 46;
    localparam int DW = 64;
    localparam int QI = 8380417;
    localparam longint QL = 64'd8380417;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic clk = 1'b0, aresetn = 1'b0, Matrix_mul_start = 1'b0;
    logic [3:0] column_length = '0;
    logic Rm_tvalid = 1'b0, Rm_tready, Rm_tlast = 1'b0;
    logic [DW-1:0] Rm_tdata = '0;
    logic Ws_tvalid, Ws_tready = 1'b0, Ws_tlast;
    logic [DW-1:0] Ws_tdata;
    logic [7:0] Ws_tkeep;
    logic coef_we, coef_enb, Matrix_mul_done, busy, proto_err;
    logic [6:0] coef_addra, coef_addrb;
    logic [PW-1:0] coef_dina, coef_doutb = '0, mat_a, mat_b, mul_result;
`ifdef PWM_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, done_cyc = -1, out_cnt = 0, last_out_cyc = -1;
    int first_valid_cyc = -1, first_acc_cyc = -1, load_last_cyc = -1, max_cnt = 0, stall_pct = 0;
    bit tvalid_seen = 0;
    int vec [NB][2];
    exp_t exp_q[$];
    logic [PW-1:0] bram [NB];
    logic [PW-1:0] mp [ML];

    pwm_lane_ctrl #(.MUL_LAT(ML)) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .Matrix_mul_start(Matrix_mul_start),
        .column_length   (column_length),
        .Rm_tvalid       (Rm_tvalid),
        .Rm_tready       (Rm_tready),
        .Rm_tdata        (Rm_tdata),
        .Rm_tlast        (Rm_tlast),
        .Ws_tvalid       (Ws_tvalid),
        .Ws_tready       (Ws_tready),
        .Ws_tdata        (Ws_tdata),
        .Ws_tkeep        (Ws_tkeep),
        .Ws_tlast        (Ws_tlast),
        .coef_we         (coef_we),
        .coef_addra      (coef_addra),
        .coef_dina       (coef_dina),
        .coef_enb        (coef_enb),
        .coef_addrb      (coef_addrb),
        .coef_doutb      (coef_doutb),
        .mat_a           (mat_a),
        .mat_b           (mat_b),
        .mul_result      (mul_result),
        .Matrix_mul_done (Matrix_mul_done),
        .busy            (busy),
        .proto_err       (proto_err)
`ifdef PWM_STATS_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int mm(input int a, input int b);
        return int'((longint'(a) * longint'(b)) % QL);
    endfunction

    function automatic logic [PW-1:0] modmul(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] r;
        for (int l = 0; l < 2; l++) r[23*l +: 23] = 23'(mm(int'(a[23*l +: 23]), int'(b[23*l +: 23])));
        return r;
    endfunction

    always @(posedge clk) begin
        if (coef_we) bram[coef_addra] <= coef_dina;
        if (coef_enb) coef_doutb <= bram[coef_addrb];
        mp[0] <= modmul(mat_a, mat_b);
        for (int i = 1; i < ML; i++) mp[i] <= mp[i-1];
    end
    assign mul_result = mp[ML-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output side: drives Ws_tready, scores every Ws handshake and records timing events.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            Ws_tready = $urandom_range(0, 99) >= stall_pct;
            #1;
            if (Matrix_mul_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (Ws_tvalid) tvalid_seen = 1;
            if (Ws_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
            if (Ws_tvalid && Ws_tready) begin
                out_cnt++;
                last_out_cyc = cyc;
                chk("ws_expected_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ws_data", Ws_tdata, e.d);
                    chk("ws_last", Ws_tlast, e.l);
                end
            end
        end
    end

    task automatic send_beat(input int a0, input int a1, input logic last, input bit bub, output bit ok);
        int to = 0;
        bit hs = 0;
        while (!hs && to < 3000) begin
            @(negedge clk);
            to++;
            if (bub && $urandom_range(0, 4) == 0) Rm_tvalid = 1'b0;
            else begin
                Rm_tvalid = 1'b1;
                Rm_tdata = {9'($urandom), 23'(a1), 9'($urandom), 23'(a0)};
                Rm_tlast = last;
            end
            #1;
            hs = Rm_tvalid && Rm_tready;
        end
        ok = hs;
        chk("rm_handshake", hs, 1);
    endtask

    task automatic idle_rm();
        @(negedge clk);
        Rm_tvalid = 1'b0;
        Rm_tlast = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] cl);
        @(negedge clk);
        Matrix_mul_start = 1'b1;
        column_length = cl;
        @(negedge clk);
        Matrix_mul_start = 1'b0;
        column_length = 4'($urandom);
        #2;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic load_vec(input bit rnd);
        bit ok;
        for (int k = 0; k < NB; k++) begin
            vec[k][0] = rnd ? $urandom_range(0, QI - 1) : 2 * k;
            vec[k][1] = rnd ? $urandom_range(0, QI - 1) : 2 * k + 1;
            send_beat(vec[k][0], vec[k][1], k == NB - 1, rnd, ok);
            if (ok) begin
                chk("coef_we", coef_we, 1);
                chk("coef_addra", coef_addra, k);
                chk("coef_dina", coef_dina, {23'(vec[k][1]), 23'(vec[k][0])});
            end
            load_last_cyc = cyc;
        end
        idle_rm();
    endtask

    task automatic compute(input int g0, input int g1, input int bad, input bit bub);
        bit ok;
        int a0, a1, k;
        exp_t e;
        for (int g = g0; g < g1; g++) begin
            k = g % NB;
            a0 = $urandom_range(0, QI - 1);
            a1 = $urandom_range(0, QI - 1);
            e.d = {9'd0, 23'(mm(a1, vec[k][1])), 9'd0, 23'(mm(a0, vec[k][0]))};
            e.l = k == NB - 1;
            exp_q.push_back(e);
            send_beat(a0, a1, (k == NB - 1) || (g == bad), bub, ok);
            if (g == g0) first_acc_cyc = cyc;
        end
        idle_rm();
    endtask

    task automatic wait_done(input int prev);
        int to = 0;
        while (done_cnt == prev && to < 5000) begin
            @(negedge clk);
            #2;
            to++;
        end
        chk("done_seen", done_cnt != prev, 1);
    endtask

    initial begin
        int o0, d0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ws_tvalid", Ws_tvalid, 0);
        chk("rst_rm_tready", Rm_tready, 0);
        chk("rst_done", Matrix_mul_done, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_tkeep", Ws_tkeep, 8'hff);
        chk("rst_coef_we", coef_we, 0);
        chk("rst_mat_a", mat_a, 0);
        chk("rst_ws_tdata", Ws_tdata, 0);
        @(negedge clk);
        aresetn = 1'b1;

        // load ramp vector, then four polys at full Ws throughput
        do_start(4'd4);
        load_vec(0);
        chk("t1_proto_err", proto_err, 0);
        o0 = out_cnt;
        d0 = done_cnt;
        first_valid_cyc = -1;
        compute(0, 4 * NB, -1, 0);
        wait_done(d0);
        chk("t2_first_latency", first_valid_cyc - first_acc_cyc, ML + 2);
        chk("t2_out_count", out_cnt - o0, 4 * NB);
        chk("t2_done_latency", done_cyc - last_out_cyc, 1);
        chk("t2_scoreboard_empty", exp_q.size(), 0);
        chk("t2_done_once", done_cnt - d0, 1);
        @(negedge clk);
        #2;
        chk("t2_idle", busy, 0);

        // random backpressure and bubbles, start held high while busy
        stall_pct = 30;
        do_start(4'd3);
        load_vec(1);
        o0 = out_cnt;
        d0 = done_cnt;
        Matrix_mul_start = 1'b1;
        compute(0, 3 * NB, -1, 1);
        Matrix_mul_start = 1'b0;
        wait_done(d0);
        chk("t3_out_count", out_cnt - o0, 3 * NB);
        chk("t3_done_latency", done_cyc - last_out_cyc, 1);
        chk("t3_fifo_max_le7", max_cnt <= 7, 1);
        chk("t3_scoreboard_empty", exp_q.size(), 0);
        stall_pct = 0;

        // stray tlast on beat 64
        do_start(4'd1);
        load_vec(1);
        o0 = out_cnt;
        d0 = done_cnt;
        compute(0, 65, 64, 0);
        @(negedge clk);
        #2;
        chk("t5_proto_err_set", proto_err, 1);
        compute(65, NB, 64, 0);
        wait_done(d0);
        chk("t5_proto_err_sticky", proto_err, 1);
        chk("t5_out_count", out_cnt - o0, NB);

        // zero columns: done right after load, nothing on Ws
        tvalid_seen = 0;
        d0 = done_cnt;
        do_start(4'd0);
        chk("t5_proto_err_cleared", proto_err, 0);
        load_vec(1);
        wait_done(d0);
        chk("t4_done_latency", done_cyc - load_last_cyc, 1);
        chk("t4_no_ws_tvalid", tvalid_seen, 0);
        @(negedge clk);
        #2;
        chk("t4_idle", busy, 0);

        // abort mid-compute at beat 200
        do_start(4'd2);
        load_vec(1);
        compute(0, 201, -1, 0);
        d0 = done_cnt;
        #3;
        aresetn = 1'b0;
        #1;
        chk("t6_busy_abort", busy, 0);
        chk("t6_ws_tvalid_abort", Ws_tvalid, 0);
        chk("t6_rm_tready_abort", Rm_tready, 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        chk("t6_no_done", done_cnt - d0, 0);
        aresetn = 1'b1;
        do_start(4'd1);
        load_vec(0);
        o0 = out_cnt;
        d0 = done_cnt;
        first_valid_cyc = -1;
        compute(0, NB, -1, 0);
        wait_done(d0);
        chk("t6_first_latency", first_valid_cyc - first_acc_cyc, ML + 2);
        chk("t6_out_count", out_cnt - o0, NB);
        chk("t6_proto_err", proto_err, 0);
        chk("t6_done_latency", done_cyc - last_out_cyc, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
